// File: rtl/hvac_zone_scheduler.sv
// hvac_zone_scheduler: round-robin sharing of one heat/cool plant across four zones with min/max on-time and dead time
module hvac_zone_scheduler #(
  parameter int SETPOINT = 20,
  parameter int HYST = 2,
  parameter int MIN_ON = 8,
  parameter int MAX_ON = 32,
  parameter int DEADTIME = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [19:0] zone_temp,
  output logic        heat,
  output logic        cool,
  output logic [3:0]  zone_valve,
  output logic [1:0]  zone_sel,
  output logic        busy
);
  localparam logic [1:0] IDLE = 2'd0, HEAT = 2'd1, COOL = 2'd2, DEAD = 2'd3;
  localparam int RW = $clog2(MAX_ON + 1);
  localparam int DW = $clog2(DEADTIME + 1);
  localparam logic [4:0] LO = 5'(SETPOINT - HYST), HI = 5'(SETPOINT + HYST), SP = 5'(SETPOINT);
  localparam logic [RW-1:0] MIN_C = RW'(MIN_ON), MAX_C = RW'(MAX_ON);
  localparam logic [DW-1:0] DEAD_C = DW'(DEADTIME);
  logic [3:0] heat_need, cool_need, need, valve_q;
  logic [1:0] state_q, state_d, sel_q, sel_d, rr_q, rr_d, pick;
  logic [RW-1:0] run_q, run_d;
  logic [DW-1:0] dead_q, dead_d;
  logic [4:0] t_sel;
  logic found, sat, opp, others, rel, heat_q, cool_q, busy_q;
  for (genvar i = 0; i < 4; i++) begin : g_need
    assign heat_need[i] = zone_temp[5*i +: 5] < LO;
    assign cool_need[i] = zone_temp[5*i +: 5] > HI;
  end
  assign need = heat_need | cool_need;
  always_comb begin
    pick = rr_q;
    found = 1'b0;
    for (int k = 3; k >= 0; k--)
      if (need[rr_q + 2'(k)]) begin
        pick = rr_q + 2'(k);
        found = 1'b1;
      end
  end
  assign t_sel = zone_temp[5*sel_q +: 5];
  assign sat = state_q == HEAT ? t_sel >= SP : t_sel <= SP;
  assign opp = state_q == HEAT ? cool_need[sel_q] : heat_need[sel_q];
  assign others = |(need & ~(4'b1 << sel_q));
  assign rel = !enable || opp || (run_q >= MIN_C && sat) || (run_q >= MAX_C && others);
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    rr_d = rr_q;
    run_d = run_q;
    dead_d = dead_q;
    if (state_q == IDLE) begin
      if (enable && found) begin
        state_d = heat_need[pick] ? HEAT : COOL;
        sel_d = pick;
        run_d = RW'(1);
      end
    end else if (state_q == DEAD) begin
      dead_d = dead_q - DW'(1);
      state_d = dead_q <= DW'(1) ? IDLE : DEAD;
    end else if (rel) begin
      state_d = DEAD;
      rr_d = sel_q + 2'd1;
      dead_d = DEAD_C;
    end else begin
      run_d = run_q == MAX_C ? run_q : run_q + RW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q <= '0;
      rr_q <= '0;
      run_q <= '0;
      dead_q <= '0;
      heat_q <= 1'b0;
      cool_q <= 1'b0;
      valve_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      rr_q <= rr_d;
      run_q <= run_d;
      dead_q <= dead_d;
      heat_q <= state_d == HEAT;
      cool_q <= state_d == COOL;
      valve_q <= (state_d == HEAT || state_d == COOL) ? 4'b1 << sel_d : 4'b0;
      busy_q <= state_d != IDLE;
    end
  end
  assign heat = heat_q;
  assign cool = cool_q;
  assign zone_valve = valve_q;
  assign zone_sel = sel_q;
  assign busy = busy_q;
endmodule

// File: doc/hvac_zone_scheduler.md
Name: hvac_zone_scheduler

Overview:
Shares one heating/cooling plant between four thermal zones. Each zone supplies a 5-bit unsigned temperature. The block grants the plant to one zone at a time in round-robin order, selects heat or cool mode, and enforces minimum on-time, maximum on-time and heat/cool changeover dead time. It sits above the single-room AC controller and drives the plant enables and the zone valves.

Parameters:
SETPOINT, 20, target temperature (0..31)
HYST, 2, hysteresis band; legal only when SETPOINT-HYST >= 1 and SETPOINT+HYST <= 30
MIN_ON, 8, minimum consecutive cycles heat/cool stays high per grant (>= 1)
MAX_ON, 32, cycles after which the grant is released if another zone is waiting (> MIN_ON)
DEADTIME, 4, cycles with heat=cool=0 after every release (>= 1)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
enable  input  1  plant enable; low forces release
zone_temp  input  20  zone i temperature on bits [5i+4:5i], unsigned
heat  output  1  plant heating enable, registered
cool  output  1  plant cooling enable, registered
zone_valve  output  4  one-hot open valve of the granted zone, 0 when not granted
zone_sel  output  2  index of the granted or last granted zone
busy  output  1  high in HEAT, COOL or DEAD

Behaviour:
- Reset (rst high at an edge): state IDLE, heat=0, cool=0, zone_valve=0, zone_sel=0, busy=0, rr_ptr=0, counters=0. Reset overrides every other input, including mid-grant: heat/cool drop on that same edge, with no dead time.
- Per-zone need, combinational: heat_need[i] = temp<SETPOINT-HYST. cool_need[i] = temp>SETPOINT+HYST. The two are mutually exclusive.
- Satisfied: heat grant when temp>=SETPOINT. Cool grant when temp<=SETPOINT.
- State IDLE:
  - Outputs heat=cool=0, zone_valve=0, busy=0.
  - If enable=1 and any zone has a need, pick the first needing zone scanning rr_ptr, rr_ptr+1, ... (mod 4).
  - Next edge: go to HEAT or COOL per that zone's need, zone_sel=zone, zone_valve=1<<zone, run_cnt=1.
  - Latency is one cycle from the need being sampled to heat/cool high.
- States HEAT and COOL:
  - heat=1 (HEAT) or cool=1 (COOL); valve held; run_cnt increments each cycle, saturating at MAX_ON.
  - Release to DEAD on the next edge when any of these holds:
    (a) enable=0, immediate, ignores MIN_ON;
    (b) granted zone needs the opposite mode, immediate;
    (c) run_cnt>=MIN_ON and the zone is satisfied;
    (d) run_cnt>=MAX_ON and any other zone has a need.
  - Without (a) or (b), heat/cool is high for at least MIN_ON cycles.
  - With no other zone needing, the grant continues past MAX_ON until satisfied.
- On release: rr_ptr=zone_sel+1 mod 4, dead_cnt=DEADTIME, heat=cool=0, zone_valve=0.
- State DEAD:
  - Outputs off, busy=1, zone_sel holds.
  - dead_cnt decrements; on the edge where it reaches 0, go to IDLE.
  - Heat=cool=0 for exactly DEADTIME cycles, then at least one IDLE cycle. Minimum off gap between grants is DEADTIME+1 cycles.
- Invariants, every cycle: heat&cool never both 1. zone_valve is 0 or one-hot. zone_valve!=0 iff heat|cool.
- Simultaneous needs: only the round-robin order decides; mode follows the chosen zone. A zone whose need vanishes before it is scanned is skipped.
- enable=0 in IDLE: no grant. enable=0 in DEAD: dead time still completes.

Test Plan:
1. Reset, all zones at 20, enable=1 for 50 cycles -> heat=cool=0, zone_valve=0, busy=0 throughout.
2. Zone1=15, others 20 -> heat=1, zone_valve=4'b0010 one cycle after the need is sampled. Set zone1=20 at grant cycle 3 -> heat stays high through cycle 8, then 4 cycles with heat=cool=0, busy=1, then IDLE.
3. Zones 0 and 2 =25, rr_ptr=0 -> zone 0 gets cool. Release -> zone 2 gets cool after ≥5 off cycles. Zone 0 still at 25 -> served only after zone 2 (round-robin order).
4. Zone3=10 never satisfied, zone0=26 waiting -> heat released at run_cnt 32, DEADTIME gap, then cool with zone_valve=4'b0001.
5. Granted heat on zone1, zone1 jumps 15->24 -> heat drops next edge, no MIN_ON wait, dead time, then cool on zone1. Check heat&cool never both 1.
6. Mid-grant enable=0 -> release next edge and dead time completes. rst pulse during HEAT -> heat=0 and state IDLE on that edge, no dead time.
